// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM command-bus monitor: command and tracker-state
// encodings plus the pin-to-command decoder.
package sdram_mon_pkg;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_ROW_OPEN    = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } state_e;

    function automatic cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
        cmd_e cmd;
        case ({ras_n, cas_n, we_n})
            3'b111:  cmd = CMD_NOP;
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_RD;
            3'b100:  cmd = CMD_WR;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_LMR;
            3'b110:  cmd = CMD_BST;
            default: cmd = CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: clear first, then increment until all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decodes commands, tracks single-bank row
// state with timing checks, counts commands and raises sticky violation flags.
module sdram_cmd_monitor
    import sdram_mon_pkg::*;
#(
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int T_REF_MAX = 1560,
    parameter int CNT_W     = 16
) (
    input  logic             sdram_clk,
    input  logic             sdram_rst,
    input  logic             sdram_ras_n,
    input  logic             sdram_cas_n,
    input  logic             sdram_we_n,
    input  logic             mon_en,
    input  logic             clr_i,
    output logic [2:0]       cmd_o,
    output logic             cmd_vld_o,
    output logic [CNT_W-1:0] act_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] ref_cnt_o,
    output logic             err_trcd_o,
    output logic             err_trp_o,
    output logic             err_trfc_o,
    output logic             err_ref_o,
    output logic             err_seq_o,
    output logic             err_any_o
);

    localparam int TMR_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                            : ((T_RP  > T_RFC) ? T_RP  : T_RFC);
    // Timer holds T-1, so log2 of the largest T is enough.
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int WD_W  = (T_REF_MAX > 1) ? $clog2(T_REF_MAX + 1) : 1;

    localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] RFC_LOAD = TMR_W'(T_RFC - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(T_REF_MAX);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(T_REF_MAX - 1);

    cmd_e             cmd_s;
    logic             is_nop_s;
    state_e           state_r;
    state_e           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    state_e           idle_nxt_s;
    logic             idle_seq_s;
    state_e           row_nxt_s;
    logic             row_seq_s;
    logic             trcd_hit_s;
    logic             trp_hit_s;
    logic             trfc_hit_s;
    logic             seq_hit_s;
    logic             wd_arm_r;
    logic [WD_W-1:0]  wd_cnt_r;
    logic             wd_hit_s;
    logic [2:0]       cmd_r;
    logic             cmd_vld_r;
    logic             err_trcd_r;
    logic             err_trp_r;
    logic             err_trfc_r;
    logic             err_ref_r;
    logic             err_seq_r;

    assign cmd_s    = decode_cmd(sdram_ras_n, sdram_cas_n, sdram_we_n);
    assign is_nop_s = (cmd_s == CMD_NOP);

    // Rule tables for IDLE and ROW_OPEN, shared by the timed states after a violation.
    always_comb begin
        idle_nxt_s = ST_IDLE;
        idle_seq_s = 1'b0;
        row_nxt_s  = ST_ROW_OPEN;
        row_seq_s  = 1'b0;
        case (cmd_s)
            CMD_ACT:          idle_nxt_s = ST_ACTIVATING;
            CMD_PRE:          idle_nxt_s = ST_PRECHARGING;
            CMD_REF:          idle_nxt_s = ST_REFRESHING;
            CMD_NOP, CMD_LMR: idle_nxt_s = ST_IDLE;
            default:          idle_seq_s = 1'b1;
        endcase
        case (cmd_s)
            CMD_NOP, CMD_RD, CMD_WR, CMD_BST: row_nxt_s = ST_ROW_OPEN;
            CMD_PRE:                          row_nxt_s = ST_PRECHARGING;
            default:                          row_seq_s = 1'b1;
        endcase
    end

    // Next-state, timer and violation decode for the row tracker.
    always_comb begin
        state_nxt_s = state_r;
        trcd_hit_s  = 1'b0;
        trp_hit_s   = 1'b0;
        trfc_hit_s  = 1'b0;
        seq_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = idle_nxt_s;
                seq_hit_s   = idle_seq_s;
            end
            ST_ACTIVATING: begin
                if (is_nop_s) begin
                    state_nxt_s = (timer_r == '0) ? ST_ROW_OPEN : ST_ACTIVATING;
                end else begin
                    trcd_hit_s  = (timer_r != '0);
                    state_nxt_s = row_nxt_s;
                    seq_hit_s   = row_seq_s;
                end
            end
            ST_ROW_OPEN: begin
                state_nxt_s = row_nxt_s;
                seq_hit_s   = row_seq_s;
            end
            ST_PRECHARGING: begin
                if (is_nop_s) begin
                    state_nxt_s = (timer_r == '0) ? ST_IDLE : ST_PRECHARGING;
                end else begin
                    trp_hit_s   = (timer_r != '0);
                    state_nxt_s = idle_nxt_s;
                    seq_hit_s   = idle_seq_s;
                end
            end
            ST_REFRESHING: begin
                if (is_nop_s) begin
                    state_nxt_s = (timer_r == '0) ? ST_IDLE : ST_REFRESHING;
                end else begin
                    trfc_hit_s  = (timer_r != '0);
                    state_nxt_s = idle_nxt_s;
                    seq_hit_s   = idle_seq_s;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        if (timer_r != '0) begin
            timer_nxt_s = timer_r - TMR_W'(1);
        end else begin
            timer_nxt_s = timer_r;
        end
        // Any command that lands in a timed state restarts its wait.
        if (!is_nop_s) begin
            case (state_nxt_s)
                ST_ACTIVATING:  timer_nxt_s = RCD_LOAD;
                ST_PRECHARGING: timer_nxt_s = RP_LOAD;
                ST_REFRESHING:  timer_nxt_s = RFC_LOAD;
                default:        timer_nxt_s = timer_nxt_s;
            endcase
        end else begin
            timer_nxt_s = timer_nxt_s;
        end
    end

    // Tracker state and wait timer; independent of mon_en and clr_i.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) begin
            state_r <= ST_IDLE;
            timer_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Watchdog fires on the edge at which the refresh age would reach the limit.
    always_comb begin
        if (wd_arm_r && (cmd_s != CMD_REF) && (wd_cnt_r >= WD_LAST)) begin
            wd_hit_s = 1'b1;
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Refresh age counter, armed by a refresh and disarmed by clear.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) begin
            wd_arm_r <= 1'b0;
            wd_cnt_r <= '0;
        end else if (clr_i) begin
            wd_arm_r <= 1'b0;
            wd_cnt_r <= '0;
        end else if (cmd_s == CMD_REF) begin
            wd_arm_r <= 1'b1;
            wd_cnt_r <= WD_W'(1);
        end else if (wd_arm_r && (wd_cnt_r != WD_LIMIT)) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Registered view of the command bus.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) begin
            cmd_r     <= 3'b111;
            cmd_vld_r <= 1'b0;
        end else begin
            cmd_r     <= {sdram_ras_n, sdram_cas_n, sdram_we_n};
            cmd_vld_r <= !is_nop_s;
        end
    end

    // Sticky violation flags; clear beats a same-cycle set.
    always_ff @(posedge sdram_clk or negedge sdram_rst) begin
        if (!sdram_rst) begin
            err_trcd_r <= 1'b0;
            err_trp_r  <= 1'b0;
            err_trfc_r <= 1'b0;
            err_ref_r  <= 1'b0;
            err_seq_r  <= 1'b0;
        end else if (clr_i) begin
            err_trcd_r <= 1'b0;
            err_trp_r  <= 1'b0;
            err_trfc_r <= 1'b0;
            err_ref_r  <= 1'b0;
            err_seq_r  <= 1'b0;
        end else if (mon_en) begin
            err_trcd_r <= err_trcd_r | trcd_hit_s;
            err_trp_r  <= err_trp_r  | trp_hit_s;
            err_trfc_r <= err_trfc_r | trfc_hit_s;
            err_ref_r  <= err_ref_r  | wd_hit_s;
            err_seq_r  <= err_seq_r  | seq_hit_s;
        end else begin
            err_trcd_r <= err_trcd_r;
            err_trp_r  <= err_trp_r;
            err_trfc_r <= err_trfc_r;
            err_ref_r  <= err_ref_r;
            err_seq_r  <= err_seq_r;
        end
    end

    sat_counter #(.W(CNT_W)) u_act_cnt (
        .clk(sdram_clk), .rst_n(sdram_rst), .clr(clr_i),
        .inc(mon_en && (cmd_s == CMD_ACT)), .count(act_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_rd_cnt (
        .clk(sdram_clk), .rst_n(sdram_rst), .clr(clr_i),
        .inc(mon_en && (cmd_s == CMD_RD)), .count(rd_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk(sdram_clk), .rst_n(sdram_rst), .clr(clr_i),
        .inc(mon_en && (cmd_s == CMD_WR)), .count(wr_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_ref_cnt (
        .clk(sdram_clk), .rst_n(sdram_rst), .clr(clr_i),
        .inc(mon_en && (cmd_s == CMD_REF)), .count(ref_cnt_o)
    );

    assign cmd_o      = cmd_r;
    assign cmd_vld_o  = cmd_vld_r;
    assign err_trcd_o = err_trcd_r;
    assign err_trp_o  = err_trp_r;
    assign err_trfc_o = err_trfc_r;
    assign err_ref_o  = err_ref_r;
    assign err_seq_o  = err_seq_r;
    assign err_any_o  = err_trcd_r | err_trp_r | err_trfc_r | err_ref_r | err_seq_r;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed self-checking bench for sdram_cmd_monitor (T_RCD=3, T_RP=3,
// T_RFC=7, T_REF_MAX=20, CNT_W=4).
module tb_sdram_cmd_monitor;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    logic       sdram_clk = 1'b0;
    logic       sdram_rst = 1'b0;
    logic       sdram_ras_n = 1'b1;
    logic       sdram_cas_n = 1'b1;
    logic       sdram_we_n  = 1'b1;
    logic       mon_en = 1'b1;
    logic       clr_i  = 1'b0;
    logic [2:0] cmd_o;
    logic       cmd_vld_o;
    logic [3:0] act_cnt_o, rd_cnt_o, wr_cnt_o, ref_cnt_o;
    logic       err_trcd_o, err_trp_o, err_trfc_o, err_ref_o, err_seq_o, err_any_o;

    int n_cmp = 0;
    int n_err = 0;

    sdram_cmd_monitor #(
        .T_RCD(3), .T_RP(3), .T_RFC(7), .T_REF_MAX(20), .CNT_W(4)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .mon_en(mon_en), .clr_i(clr_i),
        .cmd_o(cmd_o), .cmd_vld_o(cmd_vld_o),
        .act_cnt_o(act_cnt_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .ref_cnt_o(ref_cnt_o),
        .err_trcd_o(err_trcd_o), .err_trp_o(err_trp_o), .err_trfc_o(err_trfc_o),
        .err_ref_o(err_ref_o), .err_seq_o(err_seq_o), .err_any_o(err_any_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one command for one cycle; return just after the sampling edge.
    task automatic cyc(input logic [2:0] c);
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(C_NOP);
    endtask

    task automatic do_reset();
        {sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
        clr_i = 1'b0;
        mon_en = 1'b1;
        sdram_rst = 1'b0;
        @(negedge sdram_clk);
        sdram_rst = 1'b1;
        @(posedge sdram_clk);
        #1;
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_eq("rst_cmd", cmd_o, 3'b111);
        check_eq("rst_vld", cmd_vld_o, 1'b0);
        check_eq("rst_act", act_cnt_o, 4'd0);
        check_eq("rst_err", err_any_o, 1'b0);

        // Legal ACT/RD/PRE/ACT sequence at exact minimum spacing.
        cyc(C_ACT); nops(2); cyc(C_RD);
        check_eq("rd_cmd", cmd_o, 3'b101);
        check_eq("rd_vld", cmd_vld_o, 1'b1);
        cyc(C_PRE); nops(2);
        check_eq("nop_vld", cmd_vld_o, 1'b0);
        cyc(C_ACT);
        check_eq("seq1_err", err_any_o, 1'b0);
        check_eq("seq1_act", act_cnt_o, 4'd2);
        check_eq("seq1_rd", rd_cnt_o, 4'd1);

        // tRCD violation, then clear.
        do_reset();
        cyc(C_ACT); nops(1); cyc(C_WR);
        check_eq("trcd_err", err_trcd_o, 1'b1);
        check_eq("trcd_wr", wr_cnt_o, 4'd1);
        check_eq("trcd_noseq", err_seq_o, 1'b0);
        nops(3);
        clr_i = 1'b1; cyc(C_NOP); clr_i = 1'b0;
        check_eq("clr_trcd", err_trcd_o, 1'b0);
        check_eq("clr_wr", wr_cnt_o, 4'd0);
        check_eq("clr_act", act_cnt_o, 4'd0);

        // Clear wins over a same-cycle increment and error.
        clr_i = 1'b1; cyc(C_RD); clr_i = 1'b0;
        check_eq("clr_pri_rd", rd_cnt_o, 4'd0);
        check_eq("clr_pri_seq", err_seq_o, 1'b0);

        // tRFC: one cycle early is a violation, exact spacing is legal.
        do_reset();
        cyc(C_REF); nops(5); cyc(C_ACT);
        check_eq("trfc_early", err_trfc_o, 1'b1);
        check_eq("trfc_ref", ref_cnt_o, 4'd1);
        do_reset();
        cyc(C_REF); nops(6); cyc(C_ACT);
        check_eq("trfc_exact", err_any_o, 1'b0);

        // tRP violation.
        do_reset();
        cyc(C_PRE); nops(1); cyc(C_ACT);
        check_eq("trp_early", err_trp_o, 1'b1);

        // Sequencing errors: READ from IDLE, ACTIVE with row open.
        do_reset();
        cyc(C_RD);
        check_eq("seq_rd_idle", err_seq_o, 1'b1);
        do_reset();
        cyc(C_ACT); nops(3); cyc(C_ACT);
        check_eq("seq_act_open", err_seq_o, 1'b1);
        check_eq("seq_act_trcd", err_trcd_o, 1'b0);
        check_eq("seq_act_cnt", act_cnt_o, 4'd2);

        // mon_en low holds counters and flags.
        do_reset();
        mon_en = 1'b0;
        cyc(C_RD);
        check_eq("dis_seq", err_seq_o, 1'b0);
        check_eq("dis_rd", rd_cnt_o, 4'd0);
        mon_en = 1'b1;

        // Refresh watchdog fires at the 20-cycle mark.
        do_reset();
        cyc(C_REF); nops(18);
        check_eq("wd_before", err_ref_o, 1'b0);
        nops(1);
        check_eq("wd_fire", err_ref_o, 1'b1);

        // Refresh at cycle 19 suppresses it.
        do_reset();
        cyc(C_REF); nops(18); cyc(C_REF); nops(5);
        check_eq("wd_suppress", err_ref_o, 1'b0);

        // Clear disarms the watchdog.
        do_reset();
        cyc(C_REF); nops(10);
        clr_i = 1'b1; cyc(C_NOP); clr_i = 1'b0;
        nops(15);
        check_eq("wd_disarm", err_ref_o, 1'b0);

        // Saturation at 15 with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 14; i++) cyc(C_RD);
        check_eq("sat_14", rd_cnt_o, 4'd14);
        for (int i = 0; i < 6; i++) cyc(C_RD);
        check_eq("sat_hold", rd_cnt_o, 4'd15);

        // Asynchronous reset mid-ACTIVATING.
        do_reset();
        cyc(C_RD); cyc(C_ACT);
        #2;
        sdram_rst = 1'b0;
        #1;
        check_eq("arst_cmd", cmd_o, 3'b111);
        check_eq("arst_vld", cmd_vld_o, 1'b0);
        check_eq("arst_act", act_cnt_o, 4'd0);
        check_eq("arst_rd", rd_cnt_o, 4'd0);
        check_eq("arst_err", err_any_o, 1'b0);
        @(negedge sdram_clk);
        sdram_rst = 1'b1;
        cyc(C_RD);
        check_eq("arst_idle_seq", err_seq_o, 1'b1);
        check_eq("arst_idle_trcd", err_trcd_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
